// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core constants: tag/data widths, the reserved "no producer" tag
// and the fixed result-source numbering on the common data bus.
package tomasulo_pkg;

  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;

  localparam logic [TAG_W-1:0] TAG_NONE = '0;

  localparam int SRC_ADD   = 0;
  localparam int SRC_MUL   = 1;
  localparam int SRC_LOAD0 = 2;
  localparam int SRC_LOAD1 = 3;

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) n += int'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/cdb_broadcaster_if.sv
// Result-producer and CDB bundle for the broadcaster; master is the broadcaster,
// slave is the functional units plus the CDB snoopers.
interface cdb_broadcaster_if #(
  parameter int N_SRC  = 4,
  parameter int DATA_W = tomasulo_pkg::DATA_W,
  parameter int TAG_W  = tomasulo_pkg::TAG_W
);
  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int CNT_W = $clog2(N_SRC + 1);

  logic                    flush;
  logic [N_SRC-1:0]        req_valid;
  logic [N_SRC-1:0]        req_ready;
  logic [N_SRC*TAG_W-1:0]  req_tag;
  logic [N_SRC*DATA_W-1:0] req_data;
  logic                    cdb_valid;
  logic [TAG_W-1:0]        cdb_tag;
  logic [DATA_W-1:0]       cdb_data;
  logic [IDX_W-1:0]        cdb_src;
  logic [CNT_W-1:0]        pend_cnt;
  logic                    tag0_err;

  modport master (
    input  flush, req_valid, req_tag, req_data,
    output req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src, pend_cnt, tag0_err
  );

  modport slave (
    output flush, req_valid, req_tag, req_data,
    input  req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src, pend_cnt, tag0_err
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr,
// wrapping modulo N. Shared by the CDB and issue-port arbitration.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (int'(ptr) + k) % N;
      if (!any && req[c]) begin
        any       = 1'b1;
        grant[c]  = 1'b1;
        grant_idx = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/cdb_broadcaster.sv
// CDB producer: one holding register per functional unit, round-robin selection,
// one registered broadcast of (tag, value, source) per cycle.
module cdb_broadcaster #(
  parameter int N_SRC  = 4,
  parameter int DATA_W = tomasulo_pkg::DATA_W,
  parameter int TAG_W  = tomasulo_pkg::TAG_W
) (
  input  logic clk,
  input  logic rst_n,
  cdb_broadcaster_if.master bus
);
  import tomasulo_pkg::*;

  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int CNT_W = $clog2(N_SRC + 1);

  logic [N_SRC-1:0]  hold_vld_p0;
  logic [TAG_W-1:0]  hold_tag_p0  [N_SRC];
  logic [DATA_W-1:0] hold_data_p0 [N_SRC];
  logic [IDX_W-1:0]  rr_ptr;

  logic [N_SRC-1:0]  grant, ready, take, accept, hold_vld_nxt;
  logic [IDX_W-1:0]  grant_idx, ptr_nxt;
  logic              any, tag0_seen;

  logic              cdb_vld_p1;
  logic [TAG_W-1:0]  cdb_tag_p1;
  logic [DATA_W-1:0] cdb_data_p1;
  logic [IDX_W-1:0]  cdb_src_p1;
  logic [CNT_W-1:0]  pend_cnt_p1;
  logic              tag0_err_q;

  rr_arbiter #(.N(N_SRC), .IDX_W(IDX_W)) u_arb (
    .req       (hold_vld_p0),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  // Granted slot frees this cycle, so its source may refill on the same edge.
  always_comb begin
    ready = bus.flush ? '0 : (~hold_vld_p0 | grant);
    for (int i = 0; i < N_SRC; i++) begin
      take[i]   = bus.req_valid[i] & ready[i];
      accept[i] = take[i] & (bus.req_tag[i*TAG_W +: TAG_W] != TAG_W'(TAG_NONE));
    end
    tag0_seen    = |(take & ~accept);
    hold_vld_nxt = bus.flush ? '0 : ((hold_vld_p0 & ~grant) | accept);
    ptr_nxt      = (grant_idx == IDX_W'(N_SRC - 1)) ? '0 : grant_idx + 1'b1;
  end

  // ---- p0: holding registers (payload) ----
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_SRC; i++) begin
      if (accept[i]) begin
        hold_tag_p0[i]  <= bus.req_tag[i*TAG_W +: TAG_W];
        hold_data_p0[i] <= bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // ---- p0 -> p1: occupancy, pointer and registered CDB ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_vld_p0 <= '0;
      rr_ptr      <= '0;
      cdb_vld_p1  <= 1'b0;
      cdb_tag_p1  <= '0;
      cdb_data_p1 <= '0;
      cdb_src_p1  <= '0;
      pend_cnt_p1 <= '0;
      tag0_err_q  <= 1'b0;
    end else begin
      hold_vld_p0 <= hold_vld_nxt;
      pend_cnt_p1 <= CNT_W'(popcount(32'(hold_vld_nxt)));
      tag0_err_q  <= tag0_err_q | tag0_seen;
      cdb_vld_p1  <= any & ~bus.flush;
      if (any && !bus.flush) begin
        rr_ptr      <= ptr_nxt;
        cdb_tag_p1  <= hold_tag_p0[grant_idx];
        cdb_data_p1 <= hold_data_p0[grant_idx];
        cdb_src_p1  <= grant_idx;
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.cdb_valid = cdb_vld_p1;
  assign bus.cdb_tag   = cdb_tag_p1;
  assign bus.cdb_data  = cdb_data_p1;
  assign bus.cdb_src   = cdb_src_p1;
  assign bus.pend_cnt  = pend_cnt_p1;
  assign bus.tag0_err  = tag0_err_q;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Scoreboard bench for cdb_broadcaster: expected broadcasts are queued as requests
// are driven and compared in order whenever the CDB is valid.
module tb_cdb_broadcaster;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  cdb_broadcaster_if #(.N_SRC(4), .DATA_W(32), .TAG_W(4)) bus ();

  cdb_broadcaster #(.N_SRC(4), .DATA_W(32), .TAG_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] data;
    logic [1:0]  src;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int s, input logic [3:0] tag, input logic [31:0] data);
    bus.req_valid[s]       = 1'b1;
    bus.req_tag[s*4 +: 4]  = tag;
    bus.req_data[s*32 +: 32] = data;
  endtask

  task automatic clr_req(input int s);
    bus.req_valid[s] = 1'b0;
  endtask

  task automatic push_exp(input logic [3:0] tag, input logic [31:0] data, input logic [1:0] src);
    exp_t e;
    e.tag = tag; e.data = data; e.src = src;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.cdb_valid) begin
      if (sb_q.size() == 0) begin
        chk("cdb_unexpected", {60'd0, bus.cdb_tag}, 64'hFFFF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("cdb_tag",  64'(bus.cdb_tag),  64'(e.tag));
        chk("cdb_data", 64'(bus.cdb_data), 64'(e.data));
        chk("cdb_src",  64'(bus.cdb_src),  64'(e.src));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.req_valid = '0;
    bus.req_tag   = '0;
    bus.req_data  = '0;
    #12;
    chk("rst_ready",    64'(bus.req_ready), 64'hF);
    chk("rst_cdb_vld",  64'(bus.cdb_valid), 64'd0);
    chk("rst_cdb_tag",  64'(bus.cdb_tag),   64'd0);
    chk("rst_cdb_data", 64'(bus.cdb_data),  64'd0);
    chk("rst_cdb_src",  64'(bus.cdb_src),   64'd0);
    chk("rst_pend",     64'(bus.pend_cnt),  64'd0);
    chk("rst_tag0",     64'(bus.tag0_err),  64'd0);
    rst_n = 1'b1;

    // single request from source 1
    step();
    set_req(1, 4'd3, 32'h0000_00AA);
    push_exp(4'd3, 32'h0000_00AA, 2'd1);
    step();
    chk("single_pend1", 64'(bus.pend_cnt), 64'd1);
    chk("single_vld0",  64'(bus.cdb_valid), 64'd0);
    clr_req(1);
    step();
    chk("single_vld1",  64'(bus.cdb_valid), 64'd1);
    chk("single_pend0", 64'(bus.pend_cnt), 64'd0);
    step();
    chk("single_vld_off", 64'(bus.cdb_valid), 64'd0);

    // simultaneous requests on 0, 2, 3 from rr_ptr = 0
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    step();
    set_req(0, 4'd5, 32'h5000);
    set_req(2, 4'd6, 32'h6000);
    set_req(3, 4'd7, 32'h7000);
    push_exp(4'd5, 32'h5000, 2'd0);
    push_exp(4'd6, 32'h6000, 2'd2);
    push_exp(4'd7, 32'h7000, 2'd3);
    step();
    chk("simul_pend3", 64'(bus.pend_cnt), 64'd3);
    clr_req(0); clr_req(2); clr_req(3);
    step();
    chk("simul_pend2", 64'(bus.pend_cnt), 64'd2);
    step();
    step();
    chk("simul_pend0", 64'(bus.pend_cnt), 64'd0);
    // pointer wrapped to 0: source 0 must win over source 1
    set_req(0, 4'd8, 32'h8000);
    set_req(1, 4'd9, 32'h9000);
    push_exp(4'd8, 32'h8000, 2'd0);
    push_exp(4'd9, 32'h9000, 2'd1);
    step();
    clr_req(0); clr_req(1);
    step();
    step();
    step();

    // fairness: sources 0 and 1 held valid, rr_ptr = 2
    set_req(0, 4'd10, 32'h100);
    set_req(1, 4'd11, 32'h101);
    for (int k = 0; k < 22; k++) begin
      if (k % 2 == 0) push_exp(4'd10, 32'h100, 2'd0);
      else            push_exp(4'd11, 32'h101, 2'd1);
    end
    step();
    for (int k = 0; k < 22; k++) begin
      if (k == 20) begin
        clr_req(0); clr_req(1);
      end
      if (k < 20) chk("fair_ready", 64'(bus.req_ready[1:0]), (k % 2 == 0) ? 64'd1 : 64'd2);
      step();
    end
    chk("fair_pend0", 64'(bus.pend_cnt), 64'd0);

    // back-to-back on source 3
    for (int i = 1; i <= 8; i++) begin
      set_req(3, 4'(i), 32'h300 + 32'(i));
      #1;
      chk("b2b_ready3", 64'(bus.req_ready[3]), 64'd1);
      push_exp(4'(i), 32'h300 + 32'(i), 2'd3);
      step();
    end
    clr_req(3);
    step();
    chk("b2b_vld_last", 64'(bus.cdb_valid), 64'd1);
    step();
    chk("b2b_pend0", 64'(bus.pend_cnt), 64'd0);

    // flush discards pending results
    set_req(0, 4'd12, 32'hC00);
    set_req(1, 4'd13, 32'hD00);
    step();
    chk("flush_pend2", 64'(bus.pend_cnt), 64'd2);
    clr_req(0); clr_req(1);
    bus.flush = 1'b1;
    set_req(2, 4'd14, 32'hE00);
    #1;
    chk("flush_ready0", 64'(bus.req_ready), 64'd0);
    step();
    chk("flush_pend0", 64'(bus.pend_cnt), 64'd0);
    chk("flush_vld0",  64'(bus.cdb_valid), 64'd0);
    bus.flush = 1'b0;
    clr_req(2);
    step();
    chk("flush_after_vld", 64'(bus.cdb_valid), 64'd0);
    set_req(2, 4'd15, 32'h55);
    push_exp(4'd15, 32'h55, 2'd2);
    step();
    clr_req(2);
    chk("flush_refill_pend", 64'(bus.pend_cnt), 64'd1);
    step();
    chk("flush_refill_vld", 64'(bus.cdb_valid), 64'd1);

    // tag-0 request is consumed and flagged
    set_req(2, 4'd0, 32'hDEAD);
    #1;
    chk("tag0_ready", 64'(bus.req_ready[2]), 64'd1);
    step();
    chk("tag0_err_set", 64'(bus.tag0_err), 64'd1);
    chk("tag0_pend",    64'(bus.pend_cnt), 64'd0);
    clr_req(2);
    step();
    chk("tag0_no_bcast", 64'(bus.cdb_valid), 64'd0);
    chk("tag0_sticky",   64'(bus.tag0_err), 64'd1);

    // asynchronous reset with results pending (rr_ptr = 3)
    set_req(0, 4'd1, 32'h10);
    set_req(1, 4'd2, 32'h20);
    set_req(3, 4'd3, 32'h30);
    step();
    chk("rst_mid_pend3", 64'(bus.pend_cnt), 64'd3);
    clr_req(0); clr_req(1); clr_req(3);
    push_exp(4'd3, 32'h30, 2'd3);
    step();
    chk("rst_mid_vld1",  64'(bus.cdb_valid), 64'd1);
    chk("rst_mid_pend2", 64'(bus.pend_cnt), 64'd2);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_async_vld",   64'(bus.cdb_valid), 64'd0);
    chk("rst_async_pend",  64'(bus.pend_cnt),  64'd0);
    chk("rst_async_tag0",  64'(bus.tag0_err),  64'd0);
    chk("rst_async_ready", 64'(bus.req_ready), 64'hF);
    #1;
    rst_n = 1'b1;
    step();
    step();
    chk("post_rst_vld",  64'(bus.cdb_valid), 64'd0);
    chk("post_rst_pend", 64'(bus.pend_cnt),  64'd0);
    chk("sb_drained",    64'(sb_q.size()),   64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
